// File: rtl/alu_sequencer.sv
// alu_sequencer: valid/ready front-end for the pipelined alu with an in-order result FIFO.
// Define ALU_SEQ_CHECK_EN to carry expected values and flag mismatching results.
module alu_sequencer #(
    parameter int WORD_WIDTH  = 16,
    parameter int ALU_LATENCY = 1,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [0:2]            req_op,
    input  logic [0:WORD_WIDTH-1] req_in1,
    input  logic [0:WORD_WIDTH-1] req_in2,
    input  logic [0:WORD_WIDTH-1] req_expected,
    output logic [0:2]            alu_op,
    output logic [0:WORD_WIDTH-1] alu_in1,
    output logic [0:WORD_WIDTH-1] alu_in2,
    input  logic [0:WORD_WIDTH-1] alu_out,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [0:2]            rsp_op,
    output logic [0:WORD_WIDTH-1] rsp_data,
    output logic                  rsp_ok,
    output logic [7:0]            issue_count,
    output logic [7:0]            done_count,
    output logic [7:0]            err_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam int NT = ALU_LATENCY + 1;

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] outstanding;
    logic [AW-1:0] wr_idx;
    logic [AW-1:0] rd_idx;
    logic          accept;
    logic          pop;
    logic          push;

    logic                  tag_v     [NT];
    logic [0:2]            tag_op    [NT];
    logic [0:2]            fifo_op   [FIFO_DEPTH];
    logic [0:WORD_WIDTH-1] fifo_data [FIFO_DEPTH];

    // Credit covers in-flight tags too, so a result is never dropped.
    assign req_ready = rst_n && (outstanding < PW'(FIFO_DEPTH));
    assign accept    = req_valid && req_ready;
    assign rsp_valid = (wr_ptr != rd_ptr);
    assign pop       = rsp_valid && rsp_ready;
    assign push      = tag_v[NT-1];
    assign wr_idx    = wr_ptr[AW-1:0];
    assign rd_idx    = rd_ptr[AW-1:0];
    assign rsp_op    = rsp_valid ? fifo_op[rd_idx] : '0;
    assign rsp_data  = rsp_valid ? fifo_data[rd_idx] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_op      <= '0;
            alu_in1     <= '0;
            alu_in2     <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            outstanding <= '0;
            issue_count <= '0;
            done_count  <= '0;
            for (int i = 0; i < NT; i++) begin
                tag_v[i]  <= 1'b0;
                tag_op[i] <= '0;
            end
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_op[i]   <= '0;
                fifo_data[i] <= '0;
            end
        end else begin
            if (accept) begin
                alu_op      <= req_op;
                alu_in1     <= req_in1;
                alu_in2     <= req_in2;
                issue_count <= issue_count + 8'd1;
            end
            tag_v[0]  <= accept;
            tag_op[0] <= req_op;
            for (int i = 1; i < NT; i++) begin
                tag_v[i]  <= tag_v[i-1];
                tag_op[i] <= tag_op[i-1];
            end
            if (push) begin
                fifo_op[wr_idx]   <= tag_op[NT-1];
                fifo_data[wr_idx] <= alu_out;
                wr_ptr            <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr     <= rd_ptr + PW'(1);
                done_count <= done_count + 8'd1;
            end
            if (accept && !pop)
                outstanding <= outstanding + PW'(1);
            else if (!accept && pop)
                outstanding <= outstanding - PW'(1);
        end
    end

`ifdef ALU_SEQ_CHECK_EN
    logic [0:WORD_WIDTH-1] tag_exp [NT];
    logic                  fifo_ok [FIFO_DEPTH];
    logic [7:0]            err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= '0;
            for (int i = 0; i < NT; i++)
                tag_exp[i] <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++)
                fifo_ok[i] <= 1'b0;
        end else begin
            tag_exp[0] <= req_expected;
            for (int i = 1; i < NT; i++)
                tag_exp[i] <= tag_exp[i-1];
            if (push)
                fifo_ok[wr_idx] <= (alu_out == tag_exp[NT-1]);
            if (pop && !fifo_ok[rd_idx] && err_q != 8'hFF)
                err_q <= err_q + 8'd1;
        end
    end

    assign rsp_ok    = rsp_valid && fifo_ok[rd_idx];
    assign err_count = err_q;
`else
    logic unused_expected;
    assign unused_expected = ^req_expected;
    assign rsp_ok          = 1'b1;
    assign err_count       = 8'd0;
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed tests for alu_sequencer with a behavioural 1-cycle alu.
// Expectations follow the ALU_SEQ_CHECK_EN setting of the build.
module tb_alu_sequencer;
    localparam int W = 16;
    localparam int L = 1;
    localparam int D = 4;

    localparam logic [0:2] ALU_ADD   = 3'd0;
    localparam logic [0:2] ALU_SUB   = 3'd1;
    localparam logic [0:2] ALU_MUL   = 3'd2;
    localparam logic [0:2] ALU_XOR   = 3'd3;
    localparam logic [0:2] ALU_SLT   = 3'd4;
    localparam logic [0:2] ALU_SHIFT = 3'd5;

`ifdef ALU_SEQ_CHECK_EN
    localparam logic       OK_RST = 1'b0;
    localparam logic       MM_OK  = 1'b0;
    localparam logic [7:0] MM_ERR = 8'd1;
`else
    localparam logic       OK_RST = 1'b1;
    localparam logic       MM_OK  = 1'b1;
    localparam logic [7:0] MM_ERR = 8'd0;
`endif

    logic         clk;
    logic         rst_n;
    logic         req_valid;
    logic         req_ready;
    logic [0:2]   req_op;
    logic [0:W-1] req_in1;
    logic [0:W-1] req_in2;
    logic [0:W-1] req_expected;
    logic [0:2]   alu_op;
    logic [0:W-1] alu_in1;
    logic [0:W-1] alu_in2;
    logic [0:W-1] alu_out;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [0:2]   rsp_op;
    logic [0:W-1] rsp_data;
    logic         rsp_ok;
    logic [7:0]   issue_count;
    logic [7:0]   done_count;
    logic [7:0]   err_count;

    int total = 0;
    int passed = 0;

    alu_sequencer #(
        .WORD_WIDTH(W),
        .ALU_LATENCY(L),
        .FIFO_DEPTH(D)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_op(req_op),
        .req_in1(req_in1),
        .req_in2(req_in2),
        .req_expected(req_expected),
        .alu_op(alu_op),
        .alu_in1(alu_in1),
        .alu_in2(alu_in2),
        .alu_out(alu_out),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_op(rsp_op),
        .rsp_data(rsp_data),
        .rsp_ok(rsp_ok),
        .issue_count(issue_count),
        .done_count(done_count),
        .err_count(err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [0:W-1] alu_f(logic [0:2] op, logic [0:W-1] a,
                                           logic [0:W-1] b);
        case (op)
            ALU_ADD:   return a + b;
            ALU_SUB:   return a - b;
            ALU_MUL:   return a * b;
            ALU_XOR:   return a ^ b;
            ALU_SLT:   return ($signed(a) < $signed(b)) ? W'(1) : W'(0);
            ALU_SHIFT: return a << b[W-4:W-1];
            default:   return '0;
        endcase
    endfunction

    // Single-stage pipelined alu: samples alu_* and presents the result one edge later.
    always @(posedge clk) alu_out <= alu_f(alu_op, alu_in1, alu_in2);

    task automatic drive_req(logic [0:2] op, logic [0:W-1] a, logic [0:W-1] b,
                             logic [0:W-1] e);
        req_valid    = 1'b1;
        req_op       = op;
        req_in1      = a;
        req_in2      = b;
        req_expected = e;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        req_valid = 1'b0; req_op = '0; req_in1 = '0; req_in2 = '0;
        req_expected = '0; rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (req_ready !== 1'b0) $display("FAIL reset_ready: got %b want 0", req_ready);
        else passed++;
        total++;
        if ({alu_op, alu_in1, alu_in2} !== '0)
            $display("FAIL reset_alu: got %h/%h/%h want 0", alu_op, alu_in1, alu_in2);
        else passed++;
        total++;
        if ({rsp_valid, rsp_op, rsp_data} !== '0)
            $display("FAIL reset_rsp: got v=%b op=%0d d=%0d want 0", rsp_valid, rsp_op, rsp_data);
        else passed++;
        total++;
        if (rsp_ok !== OK_RST) $display("FAIL reset_ok: got %b want %b", rsp_ok, OK_RST);
        else passed++;
        total++;
        if ({issue_count, done_count, err_count} !== 24'd0)
            $display("FAIL reset_counts: got %0d/%0d/%0d want 0", issue_count, done_count, err_count);
        else passed++;
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (req_ready !== 1'b1) $display("FAIL ready_after_reset: got %b want 1", req_ready);
        else passed++;
    endtask

    task automatic test_single_add;
        rsp_ready = 1'b1;
        drive_req(ALU_ADD, 16'd5, 16'd7, 16'd12);
        @(negedge clk);
        req_valid = 1'b0;
        total++;
        if (alu_op !== ALU_ADD || alu_in1 !== 16'd5 || alu_in2 !== 16'd7)
            $display("FAIL single_alu_bus: got %0d %0d %0d want 0 5 7", alu_op, alu_in1, alu_in2);
        else passed++;
        total++;
        if (rsp_valid !== 1'b0 || issue_count !== 8'd1)
            $display("FAIL single_e0: got v=%b issue=%0d want 0 1", rsp_valid, issue_count);
        else passed++;
        @(negedge clk);
        total++;
        if (rsp_valid !== 1'b0) $display("FAIL single_early: got %b want 0", rsp_valid);
        else passed++;
        @(negedge clk);
        total++;
        if (rsp_valid !== 1'b1 || rsp_data !== 16'd12 || rsp_op !== ALU_ADD || rsp_ok !== 1'b1)
            $display("FAIL single_rsp: got v=%b d=%0d op=%0d ok=%b want 1 12 0 1",
                     rsp_valid, rsp_data, rsp_op, rsp_ok);
        else passed++;
        @(negedge clk);
        total++;
        if (rsp_valid !== 1'b0 || done_count !== 8'd1)
            $display("FAIL single_done: got v=%b done=%0d want 0 1", rsp_valid, done_count);
        else passed++;
    endtask

    task automatic test_back_to_back;
        logic [0:2]   ops [4] = '{ALU_SUB, ALU_MUL, ALU_SLT, ALU_SHIFT};
        logic [0:W-1] a   [4] = '{16'd15, 16'd4, 16'd5, 16'd5};
        logic [0:W-1] b   [4] = '{16'd4, 16'd9, 16'd7, 16'd3};
        logic [0:W-1] exp [4] = '{16'd11, 16'd36, 16'd1, 16'd40};
        int sent = 0;
        int got = 0;
        int last = 0;
        rsp_ready = 1'b1;
        for (int cyc = 0; cyc < 20 && got < 4; cyc++) begin
            @(negedge clk);
            if (rsp_valid) begin
                total++;
                if (rsp_data !== exp[got] || rsp_op !== ops[got] || rsp_ok !== 1'b1)
                    $display("FAIL burst_rsp%0d: got d=%0d op=%0d ok=%b want %0d %0d 1",
                             got, rsp_data, rsp_op, rsp_ok, exp[got], ops[got]);
                else passed++;
                if (got > 0) begin
                    total++;
                    if (cyc !== last + 1)
                        $display("FAIL burst_gap%0d: got cycle %0d want %0d", got, cyc, last + 1);
                    else passed++;
                end
                last = cyc;
                got++;
            end
            if (sent < 4) begin
                total++;
                if (req_ready !== 1'b1) $display("FAIL burst_ready%0d: got 0 want 1", sent);
                else passed++;
                drive_req(ops[sent], a[sent], b[sent], exp[sent]);
                sent++;
            end else begin
                req_valid = 1'b0;
            end
        end
        total++;
        if (got != 4) $display("FAIL burst_timeout: got %0d responses want 4", got);
        else passed++;
        @(negedge clk);
        total++;
        if (issue_count !== 8'd5 || done_count !== 8'd5)
            $display("FAIL burst_counts: got %0d/%0d want 5/5", issue_count, done_count);
        else passed++;
    endtask

    task automatic test_backpressure;
        int sent = 0;
        int got = 0;
        rsp_ready = 1'b0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            @(negedge clk);
            if (sent < 6) begin
                drive_req(ALU_ADD, W'(sent + 1), 16'd10, W'(sent + 11));
                if (req_ready) sent++;
            end
        end
        total++;
        if (sent != 4 || req_ready !== 1'b0)
            $display("FAIL bp_accept: got %0d accepted ready=%b want 4 0", sent, req_ready);
        else passed++;
        total++;
        if (rsp_valid !== 1'b1 || rsp_data !== 16'd11 || rsp_op !== ALU_ADD)
            $display("FAIL bp_head: got v=%b d=%0d op=%0d want 1 11 0", rsp_valid, rsp_data, rsp_op);
        else passed++;
        total++;
        if (issue_count !== 8'd9) $display("FAIL bp_issue: got %0d want 9", issue_count);
        else passed++;
        rsp_ready = 1'b1;
        for (int cyc = 0; cyc < 30 && got < 6; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (rsp_valid) begin
                total++;
                if (rsp_data !== W'(got + 11))
                    $display("FAIL bp_rsp%0d: got %0d want %0d", got, rsp_data, got + 11);
                else passed++;
                got++;
            end
            if (sent < 6) begin
                drive_req(ALU_ADD, W'(sent + 1), 16'd10, W'(sent + 11));
                if (req_ready) sent++;
            end else begin
                req_valid = 1'b0;
            end
        end
        req_valid = 1'b0;
        total++;
        if (got != 6) $display("FAIL bp_timeout: got %0d responses want 6", got);
        else passed++;
        @(negedge clk);
        total++;
        if (issue_count !== 8'd11 || done_count !== 8'd11 || rsp_valid !== 1'b0)
            $display("FAIL bp_counts: got %0d/%0d v=%b want 11/11 0",
                     issue_count, done_count, rsp_valid);
        else passed++;
    endtask

    task automatic test_mismatch;
        int wait_cyc = 0;
        rsp_ready = 1'b0;
        drive_req(ALU_XOR, 16'd9, 16'd12, 16'd6);
        @(negedge clk);
        req_valid = 1'b0;
        while (!rsp_valid && wait_cyc < 8) begin
            @(negedge clk);
            wait_cyc++;
        end
        total++;
        if (rsp_valid !== 1'b1) $display("FAIL mm_timeout: got v=%b want 1", rsp_valid);
        else passed++;
        total++;
        if (rsp_data !== 16'd5 || rsp_op !== ALU_XOR || rsp_ok !== MM_OK)
            $display("FAIL mm_rsp: got d=%0d op=%0d ok=%b want 5 3 %b",
                     rsp_data, rsp_op, rsp_ok, MM_OK);
        else passed++;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        total++;
        if (err_count !== MM_ERR || done_count !== 8'd12)
            $display("FAIL mm_err: got err=%0d done=%0d want %0d 12", err_count, done_count, MM_ERR);
        else passed++;
    endtask

    task automatic test_reset_midflight;
        int seen = 0;
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_req(ALU_ADD, W'(i + 100), 16'd1, W'(i + 101));
            @(negedge clk);
        end
        req_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        total++;
        if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || {alu_op, alu_in1, alu_in2} !== '0)
            $display("FAIL mid_reset_outs: got rdy=%b v=%b in1=%0d want 0 0 0",
                     req_ready, rsp_valid, alu_in1);
        else passed++;
        total++;
        if ({issue_count, done_count, err_count} !== 24'd0 || rsp_data !== '0)
            $display("FAIL mid_reset_counts: got %0d/%0d/%0d d=%0d want 0",
                     issue_count, done_count, err_count, rsp_data);
        else passed++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        total++;
        if (seen != 0) $display("FAIL mid_stale_rsp: got %0d responses want 0", seen);
        else passed++;
        total++;
        if ({issue_count, done_count} !== 16'd0)
            $display("FAIL mid_counts: got %0d/%0d want 0/0", issue_count, done_count);
        else passed++;
    endtask

    task automatic test_wrap;
        int sent = 0;
        int got = 0;
        int drops = 0;
        rsp_ready = 1'b1;
        for (int cyc = 0; cyc < 600 && got < 260; cyc++) begin
            @(negedge clk);
            if (rsp_valid) begin
                total++;
                if (rsp_data !== W'(got + 3))
                    $display("FAIL wrap_rsp%0d: got %0d want %0d", got, rsp_data, got + 3);
                else passed++;
                got++;
            end
            if (sent < 260) begin
                if (!req_ready) drops++;
                drive_req(ALU_ADD, W'(sent), 16'd3, W'(sent + 3));
                if (req_ready) sent++;
            end else begin
                req_valid = 1'b0;
            end
        end
        req_valid = 1'b0;
        total++;
        if (got != 260 || drops != 0)
            $display("FAIL wrap_stream: got %0d responses %0d stalls want 260 0", got, drops);
        else passed++;
        @(negedge clk);
        total++;
        if (issue_count !== 8'd4 || done_count !== 8'd4)
            $display("FAIL wrap_counts: got %0d/%0d want 4/4", issue_count, done_count);
        else passed++;
        total++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1)
            $display("FAIL wrap_idle: got v=%b rdy=%b want 0 1", rsp_valid, req_ready);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_single_add();
        test_back_to_back();
        test_backpressure();
        test_mismatch();
        test_reset_midflight();
        test_wrap();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
